pd_stream_scheduler: RTL and testbench
======================================

Name: pd_stream_scheduler

Overview:
Shares one nibble pattern detector (patterns 0-5-3-1 -> pattern1, 0-6-1-9 -> pattern2) among NUM_CH nibble-stream requesters.
- Arbitrates round-robin at frame granularity and drives the detector's enable/din.
- After each frame, inserts one flush nibble so the detector returns to Idle and no partial match carries into the next frame.
- Counts pattern1/pattern2 hits per frame and emits a one-cycle result record tagged with the channel id.

Parameters:
NUM_CH, 4, number of requester channels (2..8)
CH_W, 2, channel-id width, clog2(NUM_CH)
CNT_W, 8, width of per-frame hit counters (saturating)
FLUSH_NIBBLE, 4'hF, non-zero nibble injected after each frame to force the detector to Idle

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset; also wired to the detector's reset
ch_valid  in  NUM_CH  per-channel nibble valid
ch_data  in  4*NUM_CH  per-channel nibble, channel i at [4i+3:4i]
ch_last  in  NUM_CH  marks the final nibble of a frame
ch_ready  out  NUM_CH  per-channel accept; at most one bit high
pd_enable  out  1  detector enable
pd_din  out  4  detector nibble input
pd_pattern1  in  1  detector pattern1 (state decode, valid the cycle after a nibble is accepted)
pd_pattern2  in  1  detector pattern2
res_valid  out  1  one-cycle result strobe
res_ch  out  CH_W  channel id of the completed frame
res_p1_count  out  CNT_W  pattern1 hits in the frame
res_p2_count  out  CNT_W  pattern2 hits in the frame
busy  out  1  high in any state except IDLE

Behaviour:
Reset values:
- State IDLE; rr_ptr=0; grant=0; sample_pending=0; both counters 0.
- All outputs 0.

FSM states: IDLE, STREAM, FLUSH, REPORT.

IDLE:
- Scan ch_valid starting at rr_ptr, wrapping modulo NUM_CH. The first set bit is latched into grant; go to STREAM next cycle.
- Counters clear on grant.
- No valid bits: stay in IDLE.

STREAM:
- ch_ready[grant]=1, all other ready bits 0.
- pd_din=ch_data[grant]; pd_enable=ch_valid[grant].
- A nibble is accepted on a cycle with ch_valid[grant]&ch_ready[grant]. sample_pending <= accept.
- Valid gaps are allowed: no accept means detector enable is low and detector state holds.
- Accept with ch_last[grant]=1: go to FLUSH.

Hit sampling (applies in STREAM and FLUSH):
- When sample_pending=1: pd_pattern1 increments p1_count and pd_pattern2 increments p2_count.
- Counters saturate at 2^CNT_W-1.
- Pattern outputs are ignored when sample_pending=0, so each detector match counts exactly once even if enable stays low.

FLUSH (exactly 1 cycle):
- pd_enable=1, pd_din=FLUSH_NIBBLE, all ch_ready=0.
- The last nibble's hit is sampled this cycle; sample_pending <= 0.

REPORT (exactly 1 cycle):
- res_valid=1; res_ch=grant; res_p*_count=counter values.
- rr_ptr <= (grant+1) mod NUM_CH.
- Next state IDLE.

Result outputs: hold their last values when res_valid=0. There is no backpressure on results.

Throughput and latency:
- One nibble per cycle while streaming.
- Per-frame overhead: 3 cycles (IDLE grant, FLUSH, REPORT).
- res_valid asserts 2 cycles after the last-nibble accept edge.

Boundary conditions:
- Single-nibble frame (valid and last on the first STREAM cycle): legal; result has zero hits unless a prior state matches, which cannot happen after a flush.
- Requester deasserts valid mid-frame: grant is held indefinitely; there is no timeout.
- ch_last on a non-accepted cycle: ignored.
- Changing ch_data/ch_last of a non-granted channel: no effect.
- Reset mid-operation: immediate return to IDLE with counters and rr_ptr cleared; the detector resets simultaneously. The in-flight frame is dropped with no result.

Test Plan:
- ch0 sends 0,5,3,1(last) -> pd_din sequence 0,5,3,1,F; one res_valid with res_ch=0, p1=1, p2=0.
- ch2 sends 0,5,3,1,0,6,1,9(last) -> res_ch=2, p1=1, p2=1; res_valid exactly 2 cycles after the last accept.
- ch1 frame 0,5,3(last), then ch1 frame 1(last) -> FLUSH_NIBBLE isolates the frames; both results p1=0, p2=0.
- ch0 and ch3 both valid continuously with 2-nibble frames -> grants alternate 0,3,0,3; ch_ready never has two bits set.
- ch0 sends 0,6,1 followed by a 5-cycle valid gap, then 9(last) -> during the gap pd_enable=0 and the count is unaffected; result p2=1 (counted once).
- CNT_W=2: frame of 0,5,3,1 repeated 5 times -> p1 saturates at 3.
- Reset asserted mid-frame after 0,5,3 -> busy=0 and no res_valid; a following frame 1(last) reports p1=0.

Source files
------------

// File: rtl/pd_stream_scheduler.sv
// Frame-level round-robin scheduler that time-shares one nibble pattern
// detector among several nibble-stream requesters. After each frame it
// drives one flush nibble so the detector restarts from Idle. It counts the
// detector hits seen during the frame and emits one tagged result record.
module pd_stream_scheduler #(
   parameter int         NUM_CH       = 4,
   parameter int         CH_W         = 2,
   parameter int         CNT_W        = 8,
   parameter logic [3:0] FLUSH_NIBBLE = 4'hF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_CH-1:0]   ch_valid,
   input  logic [4*NUM_CH-1:0] ch_data,
   input  logic [NUM_CH-1:0]   ch_last,
   output logic [NUM_CH-1:0]   ch_ready,
   output logic                pd_enable,
   output logic [3:0]          pd_din,
   input  logic                pd_pattern1,
   input  logic                pd_pattern2,
   output logic                res_valid,
   output logic [CH_W-1:0]     res_ch,
   output logic [CNT_W-1:0]    res_p1_count,
   output logic [CNT_W-1:0]    res_p2_count,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH,
      REPORT
   } stateT;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   stateT            state_q, state_d;
   logic [CH_W-1:0]  grant_q, grant_d;
   logic [CH_W-1:0]  rrPtr_q, rrPtr_d;
   logic             samplePending_q, samplePending_d;
   logic [CNT_W-1:0] p1Count_q, p1Count_d;
   logic [CNT_W-1:0] p2Count_q, p2Count_d;
   logic             resValid_q, resValid_d;
   logic [CH_W-1:0]  resCh_q, resCh_d;
   logic [CNT_W-1:0] resP1_q, resP1_d;
   logic [CNT_W-1:0] resP2_q, resP2_d;

   logic [3:0]       chNibble [NUM_CH];
   logic             scanFound;
   logic [CH_W-1:0]  scanIdx;
   logic [CH_W-1:0]  scanPos;
   logic             accept;

   // Split the packed data bus into one nibble per channel so the granted
   // channel can be selected with a plain array index.
   for (genvar g = 0; g < NUM_CH; g++) begin : gNibble
      assign chNibble[g] = ch_data[4*g +: 4];
   end

   // Round-robin search: walk the channels starting at the pointer, wrapping
   // at NUM_CH, and remember the first one that has a nibble waiting.
   always_comb begin
      scanFound = 1'b0;
      scanIdx   = '0;
      scanPos   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         scanPos = CH_W'((int'(rrPtr_q) + i) % NUM_CH);
         if (!scanFound && ch_valid[scanPos]) begin
            scanFound = 1'b1;
            scanIdx   = scanPos;
         end
      end
   end

   // Next-state and output decode. The detector only advances on cycles we
   // enable it, and a hit is only counted on the cycle right after a nibble
   // was handed over, so a match that lingers during a valid gap is not
   // counted again.
   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      rrPtr_d         = rrPtr_q;
      samplePending_d = 1'b0;
      p1Count_d       = p1Count_q;
      p2Count_d       = p2Count_q;
      resValid_d      = 1'b0;
      resCh_d         = resCh_q;
      resP1_d         = resP1_q;
      resP2_d         = resP2_q;
      ch_ready        = '0;
      pd_enable       = 1'b0;
      pd_din          = 4'h0;
      accept          = 1'b0;

      case (state_q)
         IDLE: begin
            if (scanFound) begin
               grant_d   = scanIdx;
               p1Count_d = '0;
               p2Count_d = '0;
               state_d   = STREAM;
            end
         end
         STREAM: begin
            ch_ready[grant_q] = 1'b1;
            pd_din            = chNibble[grant_q];
            pd_enable         = ch_valid[grant_q];
            accept            = ch_valid[grant_q];
            samplePending_d   = accept;
            if (accept && ch_last[grant_q]) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            pd_enable = 1'b1;
            pd_din    = FLUSH_NIBBLE;
            state_d   = REPORT;
         end
         REPORT: begin
            resValid_d = 1'b1;
            resCh_d    = grant_q;
            resP1_d    = p1Count_q;
            resP2_d    = p2Count_q;
            rrPtr_d    = (int'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q == STREAM || state_q == FLUSH) && samplePending_q) begin
         if (pd_pattern1 && p1Count_q != CNT_MAX) begin
            p1Count_d = p1Count_q + 1'b1;
         end
         if (pd_pattern2 && p2Count_q != CNT_MAX) begin
            p2Count_d = p2Count_q + 1'b1;
         end
      end
   end

   // State and datapath registers; reset drops any in-flight frame silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         grant_q         <= '0;
         rrPtr_q         <= '0;
         samplePending_q <= 1'b0;
         p1Count_q       <= '0;
         p2Count_q       <= '0;
         resValid_q      <= 1'b0;
         resCh_q         <= '0;
         resP1_q         <= '0;
         resP2_q         <= '0;
      end else begin
         state_q         <= state_d;
         grant_q         <= grant_d;
         rrPtr_q         <= rrPtr_d;
         samplePending_q <= samplePending_d;
         p1Count_q       <= p1Count_d;
         p2Count_q       <= p2Count_d;
         resValid_q      <= resValid_d;
         resCh_q         <= resCh_d;
         resP1_q         <= resP1_d;
         resP2_q         <= resP2_d;
      end
   end

   assign res_valid    = resValid_q;
   assign res_ch       = resCh_q;
   assign res_p1_count = resP1_q;
   assign res_p2_count = resP2_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pd_stream_scheduler.sv
// Directed bench for pd_stream_scheduler. Two instances share the same
// requester stimulus: one with 8-bit counters and one with 2-bit counters to
// exercise saturation. Each instance has its own behavioural model of the
// nibble pattern detector.
module tb_pd_stream_scheduler;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   localparam logic [2:0] D_IDLE = 3'd0;
   localparam logic [2:0] D_Z    = 3'd1;
   localparam logic [2:0] D_Z5   = 3'd2;
   localparam logic [2:0] D_Z53  = 3'd3;
   localparam logic [2:0] D_P1   = 3'd4;
   localparam logic [2:0] D_Z6   = 3'd5;
   localparam logic [2:0] D_Z61  = 3'd6;
   localparam logic [2:0] D_P2   = 3'd7;

   typedef struct {
      int ch;
      int p1;
      int p2;
   } resT;

   logic clk = 1'b0;
   logic reset;

   logic                chValid [NUM_CH];
   logic                chLast  [NUM_CH];
   logic [3:0]          chData  [NUM_CH];
   logic [NUM_CH-1:0]   ch_valid;
   logic [NUM_CH-1:0]   ch_last;
   logic [4*NUM_CH-1:0] ch_data;

   logic [NUM_CH-1:0] ch_ready;
   logic              pd_enable;
   logic [3:0]        pd_din;
   logic              pd_pattern1, pd_pattern2;
   logic              res_valid;
   logic [CH_W-1:0]   res_ch;
   logic [7:0]        res_p1_count, res_p2_count;
   logic              busy;

   logic [NUM_CH-1:0] chReadySat;
   logic              pdEnableSat;
   logic [3:0]        pdDinSat;
   logic              pattern1Sat, pattern2Sat;
   logic              resValidSat;
   logic [CH_W-1:0]   resChSat;
   logic [1:0]        resP1Sat, resP2Sat;
   logic              busySat;

   logic [2:0] detState, detStateSat;

   int  checkCnt = 0;
   int  errorCnt = 0;
   int  edgeCnt = 0;
   int  lastAcceptEdge = 0;
   resT expQ[$];
   resT expSatQ[$];
   resT monE, monSatE;
   logic [3:0] dinLog[$];
   logic [3:0] expDin [5];

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Count rising edges so result latency can be measured in cycles.
   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   // Pack the per-channel stimulus arrays onto the DUT buses.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_valid[i]       = chValid[i];
         ch_last[i]        = chLast[i];
         ch_data[4*i +: 4] = chData[i];
      end
   end

   pd_stream_scheduler #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(8), .FLUSH_NIBBLE(4'hF)
   ) dut (
      .clk(clk), .reset(reset),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last),
      .ch_ready(ch_ready),
      .pd_enable(pd_enable), .pd_din(pd_din),
      .pd_pattern1(pd_pattern1), .pd_pattern2(pd_pattern2),
      .res_valid(res_valid), .res_ch(res_ch),
      .res_p1_count(res_p1_count), .res_p2_count(res_p2_count),
      .busy(busy)
   );

   pd_stream_scheduler #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(2), .FLUSH_NIBBLE(4'hF)
   ) dutSat (
      .clk(clk), .reset(reset),
      .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last),
      .ch_ready(chReadySat),
      .pd_enable(pdEnableSat), .pd_din(pdDinSat),
      .pd_pattern1(pattern1Sat), .pd_pattern2(pattern2Sat),
      .res_valid(resValidSat), .res_ch(resChSat),
      .res_p1_count(resP1Sat), .res_p2_count(resP2Sat),
      .busy(busySat)
   );

   // Detector transition: a 0 always restarts a match attempt, any other
   // nibble either advances along 0-5-3-1 / 0-6-1-9 or falls back to Idle.
   function automatic logic [2:0] detNext(input logic [2:0] s, input logic [3:0] n);
      if (n == 4'h0) return D_Z;
      case (s)
         D_Z:   if (n == 4'h5) return D_Z5; else if (n == 4'h6) return D_Z6;
         D_Z5:  if (n == 4'h3) return D_Z53;
         D_Z53: if (n == 4'h1) return D_P1;
         D_Z6:  if (n == 4'h1) return D_Z61;
         D_Z61: if (n == 4'h9) return D_P2;
         default: ;
      endcase
      return D_IDLE;
   endfunction

   // Detector model for the wide-counter instance; holds state when disabled.
   always @(posedge clk or posedge reset) begin
      if (reset) detState <= D_IDLE;
      else if (pd_enable) detState <= detNext(detState, pd_din);
   end
   assign pd_pattern1 = (detState == D_P1);
   assign pd_pattern2 = (detState == D_P2);

   // Detector model for the saturating instance.
   always @(posedge clk or posedge reset) begin
      if (reset) detStateSat <= D_IDLE;
      else if (pdEnableSat) detStateSat <= detNext(detStateSat, pdDinSat);
   end
   assign pattern1Sat = (detStateSat == D_P1);
   assign pattern2Sat = (detStateSat == D_P2);

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCnt++;
      if (observed !== expected) begin
         errorCnt++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Queue an expected result for both instances (2-bit one saturates at 3).
   task automatic expectResult(input int ch, input int p1, input int p2);
      resT e, s;
      e.ch = ch; e.p1 = p1; e.p2 = p2;
      s.ch = ch; s.p1 = (p1 > 3) ? 3 : p1; s.p2 = (p2 > 3) ? 3 : p2;
      expQ.push_back(e);
      expSatQ.push_back(s);
   endtask

   // Drive one frame on channel c. Nibbles are taken from frame MSB-first.
   // After nibble gapAfter is accepted, valid drops for gapLen cycles while
   // last is wiggled high to show it is ignored without valid.
   task automatic applyStimulus(input int c, input logic [127:0] frame, input int len,
                                input bit withLast, input int gapAfter, input int gapLen);
      int waitCnt;
      for (int k = 0; k < len; k++) begin
         chData[c]  = frame[4*(len-1-k) +: 4];
         chValid[c] = 1'b1;
         chLast[c]  = withLast && (k == len - 1);
         waitCnt = 0;
         @(negedge clk);
         while (!ch_ready[c] && waitCnt < 500) begin
            waitCnt++;
            @(negedge clk);
         end
         if (!ch_ready[c]) begin
            checkOutput("readyTimeout", 0, 1);
            chValid[c] = 1'b0;
            chLast[c]  = 1'b0;
            return;
         end
         if (chLast[c]) lastAcceptEdge = edgeCnt + 1;
         @(posedge clk);
         #1;
         if (k == gapAfter) begin
            chValid[c] = 1'b0;
            chLast[c]  = 1'b1;
            chData[c]  = 4'h9;
            repeat (gapLen) begin
               @(negedge clk);
               checkOutput("gapEnable", pd_enable, 0);
            end
            chLast[c] = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      chValid[c] = 1'b0;
      chLast[c]  = 1'b0;
   endtask

   // Wait (bounded) until every queued result has been seen.
   task automatic waitResults();
      int w = 0;
      while ((expQ.size() != 0 || expSatQ.size() != 0) && w < 200) begin
         @(negedge clk);
         w++;
      end
      checkOutput("resultsDrained", expQ.size() + expSatQ.size(), 0);
   endtask

   // Result monitor and grant sanity, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("readyOneHot", ($countones(ch_ready) <= 1) ? 1 : 0, 1);
         if (pd_enable) dinLog.push_back(pd_din);
         if (res_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedRes", 1, 0);
            end else begin
               monE = expQ.pop_front();
               checkOutput("resCh", res_ch, monE.ch);
               checkOutput("resP1", res_p1_count, monE.p1);
               checkOutput("resP2", res_p2_count, monE.p2);
               checkOutput("resLatency", edgeCnt - lastAcceptEdge, 2);
            end
         end
         if (resValidSat) begin
            if (expSatQ.size() == 0) begin
               checkOutput("unexpectedResSat", 1, 0);
            end else begin
               monSatE = expSatQ.pop_front();
               checkOutput("satCh", resChSat, monSatE.ch);
               checkOutput("satP1", resP1Sat, monSatE.p1);
               checkOutput("satP2", resP2Sat, monSatE.p2);
            end
         end
      end
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence.
   initial begin
      expDin[0] = 4'h0; expDin[1] = 4'h5; expDin[2] = 4'h3;
      expDin[3] = 4'h1; expDin[4] = 4'hF;
      for (int i = 0; i < NUM_CH; i++) begin
         chValid[i] = 1'b0;
         chLast[i]  = 1'b0;
         chData[i]  = 4'h0;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstResValid", res_valid, 0);
      checkOutput("rstReady", ch_ready, 0);
      checkOutput("rstEnable", pd_enable, 0);
      checkOutput("rstDin", pd_din, 0);
      checkOutput("rstResCh", res_ch, 0);
      checkOutput("rstResP1", res_p1_count, 0);
      checkOutput("rstResP2", res_p2_count, 0);

      $display("[TB] ch0 single pattern1 frame");
      dinLog.delete();
      expectResult(0, 1, 0);
      applyStimulus(0, 128'h0531, 4, 1, -1, 0);
      waitResults();
      checkOutput("dinCount", dinLog.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < dinLog.size()) checkOutput("dinSeq", dinLog[i], expDin[i]);
      end

      $display("[TB] ch2 pattern1 then pattern2");
      expectResult(2, 1, 1);
      applyStimulus(2, 128'h05310619, 8, 1, -1, 0);
      waitResults();

      $display("[TB] ch1 frames isolated by flush");
      expectResult(1, 0, 0);
      expectResult(1, 0, 0);
      applyStimulus(1, 128'h053, 3, 1, -1, 0);
      applyStimulus(1, 128'h1, 1, 1, -1, 0);
      waitResults();

      $display("[TB] ch0 valid gap inside pattern2");
      expectResult(0, 0, 1);
      applyStimulus(0, 128'h0619, 4, 1, 2, 5);
      waitResults();

      $display("[TB] ch1 five pattern1 hits in one frame");
      expectResult(1, 5, 0);
      applyStimulus(1, 128'h05310531053105310531, 20, 1, -1, 0);
      waitResults();

      $display("[TB] reset mid-frame");
      applyStimulus(2, 128'h053, 3, 0, -1, 0);
      repeat (2) @(negedge clk);
      checkOutput("busyMidFrame", busy, 1);
      reset = 1'b1;
      #1;
      checkOutput("busyAfterReset", busy, 0);
      checkOutput("readyAfterReset", ch_ready, 0);
      checkOutput("resValidAfterReset", res_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      expectResult(3, 0, 0);
      applyStimulus(3, 128'h1, 1, 1, -1, 0);
      waitResults();

      $display("[TB] ch0 and ch3 contending");
      expectResult(0, 0, 0);
      expectResult(3, 0, 0);
      expectResult(0, 0, 0);
      expectResult(3, 0, 0);
      fork
         begin
            applyStimulus(0, 128'h05, 2, 1, -1, 0);
            applyStimulus(0, 128'h31, 2, 1, -1, 0);
         end
         begin
            applyStimulus(3, 128'h06, 2, 1, -1, 0);
            applyStimulus(3, 128'h19, 2, 1, -1, 0);
         end
      join
      waitResults();

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checkCnt, errorCnt);
      $finish;
   end

endmodule
